// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU controller and its 1-bit slice.
package alu_pkg;

   // ALU operation select, as seen on the op port
   typedef enum logic [1:0] {
      OP_AND = 2'b00,
      OP_OR  = 2'b01,
      OP_ADD = 2'b10,
      OP_SLT = 2'b11
   } alu_op_e;

   // Controller sequencing states
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } ctrl_state_e;

endpackage

// File: rtl/ALU_1bit.sv
// One-bit ALU slice: AND / OR / full-adder sum / less pass-through,
// with per-operand inversion. set exposes the raw sum for SLT.
module ALU_1bit
   import alu_pkg::*;
(
   input  logic    a,
   input  logic    b,
   input  logic    Ainvert,
   input  logic    Binvert,
   input  logic    c_in,
   input  logic    less,
   input  alu_op_e op,
   output logic    result,
   output logic    c_out,
   output logic    set
);

   logic a_eff;
   logic b_eff;
   logic sum;

   // Operand conditioning, full adder and result select
   always_comb begin
      a_eff = a ^ Ainvert;
      b_eff = b ^ Binvert;
      sum   = a_eff ^ b_eff ^ c_in;
      c_out = (a_eff & b_eff) | (a_eff & c_in) | (b_eff & c_in);
      set   = sum;
      unique case (op)
         OP_AND:  result = a_eff & b_eff;
         OP_OR:   result = a_eff | b_eff;
         OP_ADD:  result = sum;
         OP_SLT:  result = less;
         default: result = 1'b0;
      endcase
   end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU controller: latches an operation on start, walks the
// operands LSB first through a single ALU_1bit slice, then publishes a
// registered result with overflow and zero flags and a one-cycle done.
module serial_alu_ctrl
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             Ainvert,
   input  logic             Binvert,
   input  logic [1:0]       op,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             overflow,
   output logic             zero
);

   localparam int unsigned IW = $clog2(WIDTH);
   localparam int unsigned CW = IW + 1;

   ctrl_state_e      state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   alu_op_e          op_q, op_d;
   logic             ainv_q, ainv_d;
   logic             binv_q, binv_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             ovf_pend_q, ovf_pend_d;
   logic             set_q, set_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             overflow_q, overflow_d;
   logic             zero_q, zero_d;
   logic             done_q, done_d;

   logic             last_bit;
   logic             slice_a;
   logic             slice_b;
   logic             slice_res;
   logic             slice_cout;
   logic             slice_set;

   assign last_bit = (state_q == ST_RUN) && (cnt_q == CW'(WIDTH - 1));
   assign slice_a  = a_q[cnt_q[IW-1:0]];
   assign slice_b  = b_q[cnt_q[IW-1:0]];

   ALU_1bit u_slice (
      .a       (slice_a),
      .b       (slice_b),
      .Ainvert (ainv_q),
      .Binvert (binv_q),
      .c_in    (carry_q),
      .less    (1'b0),
      .op      (op_q),
      .result  (slice_res),
      .c_out   (slice_cout),
      .set     (slice_set)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN:  if (last_bit) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      busy = (state_q == ST_RUN);
   end

   // Operand latch, serial datapath and completion bookkeeping
   always_comb begin
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      ainv_d     = ainv_q;
      binv_d     = binv_q;
      cnt_d      = cnt_q;
      carry_d    = carry_q;
      shreg_d    = shreg_q;
      ovf_pend_d = ovf_pend_q;
      set_d      = set_q;
      result_d   = result_q;
      overflow_d = overflow_q;
      zero_d     = zero_q;
      done_d     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               op_d    = alu_op_e'(op);
               ainv_d  = Ainvert;
               binv_d  = Binvert;
               cnt_d   = '0;
               carry_d = Binvert;
            end
         end
         ST_RUN: begin
            shreg_d = {slice_res, shreg_q[WIDTH-1:1]};
            carry_d = slice_cout;
            cnt_d   = cnt_q + CW'(1);
            // MSB-slice flags are captured as the last bit goes through
            if (last_bit) begin
               ovf_pend_d = slice_cout ^ carry_q;
               set_d      = slice_set;
            end
         end
         ST_DONE: begin
            if (op_q == OP_SLT) result_d = {{(WIDTH-1){1'b0}}, set_q};
            else                result_d = shreg_q;
            overflow_d = ovf_pend_q;
            zero_d     = (result_d == '0);
            done_d     = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= OP_AND;
         ainv_q     <= 1'b0;
         binv_q     <= 1'b0;
         cnt_q      <= '0;
         carry_q    <= 1'b0;
         shreg_q    <= '0;
         ovf_pend_q <= 1'b0;
         set_q      <= 1'b0;
         result_q   <= '0;
         overflow_q <= 1'b0;
         zero_q     <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         ainv_q     <= ainv_d;
         binv_q     <= binv_d;
         cnt_q      <= cnt_d;
         carry_q    <= carry_d;
         shreg_q    <= shreg_d;
         ovf_pend_q <= ovf_pend_d;
         set_q      <= set_d;
         result_q   <= result_d;
         overflow_q <= overflow_d;
         zero_q     <= zero_d;
         done_q     <= done_d;
      end
   end

   assign done     = done_q;
   assign result   = result_q;
   assign overflow = overflow_q;
   assign zero     = zero_q;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Scoreboard bench for serial_alu_ctrl (WIDTH=8): directed operations push
// hand-computed expectations; a negedge monitor pops one per done pulse.
module tb_serial_alu_ctrl;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ainv;
   logic         binv;
   logic [1:0]   op;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         overflow;
   logic         zero;

   serial_alu_ctrl #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a        (a),
      .b        (b),
      .Ainvert  (ainv),
      .Binvert  (binv),
      .op       (op),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .overflow (overflow),
      .zero     (zero)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] res;
      logic         ovf;
      logic         chk_ovf;
      logic         zr;
      int           due;
      string        name;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   done_cnt = 0;
   int   last_done_cyc = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endfunction

   // Monitor: one expectation consumed per done pulse
   always @(negedge clk) begin
      if (done === 1'b1) begin
         exp_t e;
         done_cnt++;
         last_done_cyc = cyc;
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk({e.name, "_result"}, 32'(result), 32'(e.res));
            if (e.chk_ovf) chk({e.name, "_overflow"}, 32'(overflow), 32'(e.ovf));
            chk({e.name, "_zero"}, 32'(zero), 32'(e.zr));
            if (e.due >= 0) chk({e.name, "_latency"}, 32'(cyc), 32'(e.due));
         end
      end
   end

   task automatic wait_done(input int base, input string nm);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         #1;
         if (done_cnt != base) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         chk({nm, "_timeout"}, 32'd0, 32'd1);
         if (sb.size() != 0) void'(sb.pop_back());
      end
   endtask

   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic iai, input logic ibi, input logic [1:0] iop,
                        input logic [W-1:0] er, input logic eo, input logic co,
                        input logic ez, input string nm);
      int s;
      int base;
      @(negedge clk);
      a = ia; b = ib; ainv = iai; binv = ibi; op = iop;
      start = 1'b1;
      base = done_cnt;
      @(posedge clk);
      #1;
      s = cyc;
      start = 1'b0;
      sb.push_back('{er, eo, co, ez, s + W + 1, nm});
      wait_done(base, nm);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int base;
      int s;
      int c1;
      int c2;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; ainv = 1'b0; binv = 1'b0; op = 2'b00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_zero", 32'(zero), 32'd1);
      rst = 1'b0;

      //    a       b       Ai    Bi    op     result  ovf   chk   zero
      issue(8'h7F, 8'h01, 1'b0, 1'b0, 2'b10, 8'h80, 1'b1, 1'b1, 1'b0, "add_ovf");
      issue(8'h05, 8'h07, 1'b0, 1'b1, 2'b10, 8'hFE, 1'b0, 1'b1, 1'b0, "sub_neg");
      issue(8'h33, 8'h33, 1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 1'b1, "sub_zero");
      issue(8'h03, 8'h05, 1'b0, 1'b1, 2'b11, 8'h01, 1'b0, 1'b1, 1'b0, "slt_lt");
      issue(8'h05, 8'h03, 1'b0, 1'b1, 2'b11, 8'h00, 1'b0, 1'b1, 1'b1, "slt_ge");
      issue(8'hF0, 8'h0F, 1'b0, 1'b0, 2'b01, 8'hFF, 1'b0, 1'b1, 1'b0, "or");
      issue(8'hF0, 8'h0F, 1'b1, 1'b1, 2'b00, 8'h00, 1'b0, 1'b1, 1'b1, "nor");
      issue(8'h80, 8'h80, 1'b0, 1'b0, 2'b10, 8'h00, 1'b1, 1'b1, 1'b1, "add_wrap");
      issue(8'hF0, 8'h3C, 1'b0, 1'b0, 2'b00, 8'h30, 1'b0, 1'b0, 1'b0, "and");

      // Reset while bit 4 of an ADD is due: abort, no done, cleared result
      @(negedge clk);
      a = 8'h11; b = 8'h22; ainv = 1'b0; binv = 1'b0; op = 2'b10;
      start = 1'b1;
      base = done_cnt;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("abort_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort_busy_after", 32'(busy), 32'd0);
      chk("abort_result", 32'(result), 32'd0);
      chk("abort_zero", 32'(zero), 32'd1);
      repeat (20) @(negedge clk);
      chk("abort_no_done", 32'(done_cnt - base), 32'd0);

      // start held through RUN and DONE, operands changed mid-flight
      @(negedge clk);
      a = 8'h12; b = 8'h34; ainv = 1'b0; binv = 1'b0; op = 2'b10;
      start = 1'b1;
      base = done_cnt;
      @(posedge clk);
      #1;
      s = cyc;
      sb.push_back('{8'h46, 1'b0, 1'b1, 1'b0, s + W + 1, "held_start"});
      @(negedge clk);
      a = 8'hFF; b = 8'hFF; op = 2'b01; binv = 1'b1;
      repeat (W + 1) @(posedge clk);
      #1;
      start = 1'b0;
      repeat (25) @(negedge clk);
      chk("held_start_done_count", 32'(done_cnt - base), 32'd1);

      // Back-to-back: second start taken in the cycle done is high
      @(negedge clk);
      a = 8'h01; b = 8'h01; ainv = 1'b0; binv = 1'b0; op = 2'b10;
      start = 1'b1;
      base = done_cnt;
      @(posedge clk);
      #1;
      s = cyc;
      sb.push_back('{8'h02, 1'b0, 1'b1, 1'b0, s + W + 1, "b2b_first"});
      sb.push_back('{8'h05, 1'b0, 1'b1, 1'b0, s + 2 * W + 3, "b2b_second"});
      @(negedge clk);
      a = 8'h02; b = 8'h03;
      wait_done(base, "b2b_first");
      c1 = last_done_cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(base + 1, "b2b_second");
      c2 = last_done_cyc;
      chk("b2b_spacing", 32'(c2 - c1), 32'(W + 2));

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
